// File: rtl/cache_miss_ctrl_pkg.sv
// Shared definitions for the cache miss controller: default widths,
// FSM state encodings and the data pattern returned on a memory timeout.
package cache_miss_ctrl_pkg;

    // Default widths and limits.
    localparam int DEF_ADDR_WIDTH  = 8;
    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_MEM_TIMEOUT = 64;
    localparam int DEF_STAT_WIDTH  = 8;

    // Widest data path supported by the timeout pattern below.
    localparam int MAX_DATA_WIDTH  = 64;

    // FSM state encodings.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOOKUP = 3'd1;
    localparam logic [2:0] ST_CHECK  = 3'd2;
    localparam logic [2:0] ST_MEM_RD = 3'd3;
    localparam logic [2:0] ST_MEM_WR = 3'd4;
    localparam logic [2:0] ST_FILL   = 3'd5;
    localparam logic [2:0] ST_RESP   = 3'd6;

    // Read data reported to the CPU when backing memory never answers.
    localparam logic [MAX_DATA_WIDTH-1:0] ERR_DATA = {MAX_DATA_WIDTH{1'b1}};

endpackage

// File: rtl/cache_miss_ctrl_sat_counter.sv
// Saturating up-counter used for the read hit and read miss statistics.
// It stops at all ones and never wraps back to zero.
module sat_counter
    import cache_miss_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_STAT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             at_max;

    assign at_max = (count_q == {WIDTH{1'b1}});

    // Next count: step by one unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && !at_max) begin
            count_d = count_q + WIDTH'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= {WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cache_miss_ctrl.sv
// Memory-access controller between the CPU data port, the lookup cache and
// backing RAM. Reads are looked up in the cache, misses are fetched from
// memory and filled; writes go through to memory and update the cache.
// Memory accesses are bounded by a timeout that reports an error to the CPU.
module cache_miss_ctrl
    import cache_miss_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int STAT_WIDTH  = DEF_STAT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    // CPU port
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ack,
    output logic                  cpu_err,
    // Cache port
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic                  cache_we,
    output logic [DATA_WIDTH-1:0] cache_wdata,
    input  logic [DATA_WIDTH-1:0] cache_rdata,
    input  logic                  cache_hit,
    // Backing memory port
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    // Statistics
    output logic [STAT_WIDTH-1:0] hit_cnt,
    output logic [STAT_WIDTH-1:0] miss_cnt
);

    // The timeout counter must be able to hold MEM_TIMEOUT itself.
    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(MEM_TIMEOUT);

    logic [2:0]            state_q,  state_d;
    logic                  we_q,     we_d;
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
    logic [TW-1:0]         tmo_q,    tmo_d;
    logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;
    logic [DATA_WIDTH-1:0] fill_q,   fill_d;
    logic                  err_q,    err_d;
    logic                  ack_q,    ack_d;
    logic                  cwe_q,    cwe_d;
    logic                  mreq_q,   mreq_d;
    logic                  mwe_q,    mwe_d;
    logic                  hit_inc;
    logic                  miss_inc;
    logic                  tmo_expired;

    // The counter holds MEM_TIMEOUT in the last cycle of a memory wait.
    assign tmo_expired = (tmo_q == TMO_MAX);

    // Next-state and next-output logic. Outputs are computed one cycle ahead
    // so that every port is driven straight from a register.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        tmo_d    = tmo_q;
        rdata_d  = rdata_q;
        fill_d   = fill_q;
        err_d    = err_q;
        ack_d    = 1'b0;
        cwe_d    = 1'b0;
        mreq_d   = 1'b0;
        mwe_d    = 1'b0;
        hit_inc  = 1'b0;
        miss_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    we_d    = cpu_we;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    if (cpu_we) begin
                        state_d = ST_MEM_WR;
                        tmo_d   = {TW{1'b0}};
                        mreq_d  = 1'b1;
                        mwe_d   = 1'b1;
                    end else begin
                        state_d = ST_LOOKUP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                // The cache registers cache_addr at the end of this cycle.
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (cache_hit) begin
                    rdata_d = cache_rdata;
                    hit_inc = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    miss_inc = 1'b1;
                    tmo_d    = {TW{1'b0}};
                    mreq_d   = 1'b1;
                    state_d  = ST_MEM_RD;
                end
            end
            ST_MEM_RD, ST_MEM_WR: begin
                // An acknowledge in the expiry cycle still completes normally.
                if (mem_ack) begin
                    if (state_q == ST_MEM_RD) begin
                        rdata_d = mem_rdata;
                        fill_d  = mem_rdata;
                    end else begin
                        fill_d  = wdata_q;
                    end
                    cwe_d   = 1'b1;
                    state_d = ST_FILL;
                end else if (tmo_expired) begin
                    err_d   = 1'b1;
                    rdata_d = ERR_DATA[DATA_WIDTH-1:0];
                    ack_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    tmo_d   = tmo_q + TW'(1);
                    mreq_d  = 1'b1;
                    mwe_d   = (state_q == ST_MEM_WR);
                    state_d = state_q;
                end
            end
            ST_FILL: begin
                ack_d   = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                // The error flag only qualifies the single ack cycle.
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset; a reset in the
    // middle of a transaction simply abandons it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= {ADDR_WIDTH{1'b0}};
            wdata_q <= {DATA_WIDTH{1'b0}};
            tmo_q   <= {TW{1'b0}};
            rdata_q <= {DATA_WIDTH{1'b0}};
            fill_q  <= {DATA_WIDTH{1'b0}};
            err_q   <= 1'b0;
            ack_q   <= 1'b0;
            cwe_q   <= 1'b0;
            mreq_q  <= 1'b0;
            mwe_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            tmo_q   <= tmo_d;
            rdata_q <= rdata_d;
            fill_q  <= fill_d;
            err_q   <= err_d;
            ack_q   <= ack_d;
            cwe_q   <= cwe_d;
            mreq_q  <= mreq_d;
            mwe_q   <= mwe_d;
        end
    end

    // Read hit statistics.
    sat_counter #(.WIDTH(STAT_WIDTH)) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit_inc),
        .count (hit_cnt)
    );

    // Read miss statistics.
    sat_counter #(.WIDTH(STAT_WIDTH)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (miss_inc),
        .count (miss_cnt)
    );

    // The captured address serves lookup, fill and memory access alike.
    assign cpu_rdata   = rdata_q;
    assign cpu_ack     = ack_q;
    assign cpu_err     = err_q;
    assign cache_addr  = addr_q;
    assign cache_we    = cwe_q;
    assign cache_wdata = fill_q;
    assign mem_req     = mreq_q;
    assign mem_we      = mwe_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;

    // The captured direction is kept for debug visibility only.
    logic unused_we;
    assign unused_we = we_q;

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed testbench for cache_miss_ctrl. Two instances share the stimulus:
// one with the default timeout and one with MEM_TIMEOUT=4 for the error path.
// A small cache model and a memory responder are advanced once per cycle.
module tb_cache_miss_ctrl;

    logic       clk = 1'b0;
    logic       rst, cpu_req, cpu_we;
    logic [7:0] cpu_addr, cpu_wdata;
    logic [7:0] cache_rdata, mem_rdata;
    logic       cache_hit, mem_ack;

    logic [7:0] m_cpu_rdata, m_cache_addr, m_cache_wdata, m_mem_addr, m_mem_wdata, m_hit_cnt, m_miss_cnt;
    logic       m_cpu_ack, m_cpu_err, m_cache_we, m_mem_req, m_mem_we;
    logic [7:0] t_cpu_rdata, t_cache_addr, t_cache_wdata, t_mem_addr, t_mem_wdata, t_hit_cnt, t_miss_cnt;
    logic       t_cpu_ack, t_cpu_err, t_cache_we, t_mem_req, t_mem_we;

    logic       sel = 1'b0;
    logic [7:0] cpu_rdata, cache_addr, cache_wdata, mem_addr, mem_wdata, hit_cnt, miss_cnt;
    logic       cpu_ack, cpu_err, cache_we, mem_req, mem_we;

    assign cpu_rdata   = sel ? t_cpu_rdata   : m_cpu_rdata;
    assign cpu_ack     = sel ? t_cpu_ack     : m_cpu_ack;
    assign cpu_err     = sel ? t_cpu_err     : m_cpu_err;
    assign cache_addr  = sel ? t_cache_addr  : m_cache_addr;
    assign cache_we    = sel ? t_cache_we    : m_cache_we;
    assign cache_wdata = sel ? t_cache_wdata : m_cache_wdata;
    assign mem_req     = sel ? t_mem_req     : m_mem_req;
    assign mem_we      = sel ? t_mem_we      : m_mem_we;
    assign mem_addr    = sel ? t_mem_addr    : m_mem_addr;
    assign mem_wdata   = sel ? t_mem_wdata   : m_mem_wdata;
    assign hit_cnt     = sel ? t_hit_cnt     : m_hit_cnt;
    assign miss_cnt    = sel ? t_miss_cnt    : m_miss_cnt;

    cache_miss_ctrl dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(m_cpu_rdata), .cpu_ack(m_cpu_ack), .cpu_err(m_cpu_err),
        .cache_addr(m_cache_addr), .cache_we(m_cache_we), .cache_wdata(m_cache_wdata),
        .cache_rdata(cache_rdata), .cache_hit(cache_hit), .mem_req(m_mem_req), .mem_we(m_mem_we),
        .mem_addr(m_mem_addr), .mem_wdata(m_mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_cnt(m_hit_cnt), .miss_cnt(m_miss_cnt)
    );

    cache_miss_ctrl #(.MEM_TIMEOUT(4)) dut_t (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(t_cpu_rdata), .cpu_ack(t_cpu_ack), .cpu_err(t_cpu_err),
        .cache_addr(t_cache_addr), .cache_we(t_cache_we), .cache_wdata(t_cache_wdata),
        .cache_rdata(cache_rdata), .cache_hit(cache_hit), .mem_req(t_mem_req), .mem_we(t_mem_we),
        .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_cnt(t_hit_cnt), .miss_cnt(t_miss_cnt)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Cache model state and previous-cycle cache port values.
    logic       cv [256];
    logic [7:0] cd [256];
    logic [7:0] prev_caddr = 8'h00;
    logic       prev_cwe = 1'b0;
    logic [7:0] prev_cwdata = 8'h00;

    // Memory responder: ack in the mem_delay-th cycle of a request (-1 = never).
    int         mem_delay = -1;
    int         mem_seen = 0;
    logic [7:0] mem_resp = 8'h00;

    // Per-transaction observations.
    int         cyc, n_mem_req, n_cache_we, n_ack, n_err, ack_at;
    logic [7:0] m_addr, m_wdata, fill_addr, fill_data, ack_rdata;
    logic       m_we, ack_err, mem_unstable;

    task automatic clear_stats();
        cyc = 0; n_mem_req = 0; n_cache_we = 0; n_ack = 0; n_err = 0; ack_at = -1;
        m_addr = 8'h00; m_wdata = 8'h00; m_we = 1'b0; fill_addr = 8'h00; fill_data = 8'h00;
        ack_rdata = 8'h00; ack_err = 1'b0; mem_unstable = 1'b0; mem_seen = 0;
    endtask

    // Advance one cycle and observe the DUT #1 after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cache_hit   = cv[prev_caddr];
        cache_rdata = cd[prev_caddr];
        if (prev_cwe) begin
            cv[prev_caddr] = 1'b1;
            cd[prev_caddr] = prev_cwdata;
        end
        prev_caddr  = cache_addr;
        prev_cwe    = cache_we;
        prev_cwdata = cache_wdata;
        cyc++;
        if (cache_we) begin
            n_cache_we++; fill_addr = cache_addr; fill_data = cache_wdata;
        end
        if (cpu_ack) begin
            n_ack++; ack_at = cyc; ack_rdata = cpu_rdata; ack_err = cpu_err;
        end
        if (cpu_err) n_err++;
        if (mem_req) begin
            if (mem_seen == 0) begin
                m_addr = mem_addr; m_we = mem_we; m_wdata = mem_wdata;
            end else if (mem_addr !== m_addr || mem_we !== m_we || mem_wdata !== m_wdata) begin
                mem_unstable = 1'b1;
            end
            n_mem_req++;
            mem_ack   = (mem_seen == mem_delay);
            mem_rdata = mem_ack ? mem_resp : 8'h00;
            mem_seen++;
        end else begin
            mem_seen  = 0;
            mem_ack   = 1'b0;
            mem_rdata = 8'h00;
        end
    endtask

    // Issue one request in cycle 0 and run until ack (bounded), plus two idle cycles.
    task automatic run_txn(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                           input int delay, input logic [7:0] resp);
        clear_stats();
        mem_delay = delay; mem_resp = resp;
        cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
        for (int i = 0; i < 200 && n_ack == 0; i++) begin
            tick();
            if (cyc == 1) cpu_req = 1'b0;
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        clear_stats();
        rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h12; cpu_wdata = 8'h77;
        tick();
        tick();
        total_cnt++; if ({cpu_ack, cpu_err, cache_we, mem_req, mem_we} !== 5'b0) $display("FAIL reset_ctrl: got %b expected 00000", {cpu_ack, cpu_err, cache_we, mem_req, mem_we}); else pass_cnt++;
        total_cnt++; if ({cpu_rdata, cache_addr, cache_wdata} !== 24'h0) $display("FAIL reset_cpu_cache: got %h expected 000000", {cpu_rdata, cache_addr, cache_wdata}); else pass_cnt++;
        total_cnt++; if ({mem_addr, mem_wdata, hit_cnt, miss_cnt} !== 32'h0) $display("FAIL reset_mem_stats: got %h expected 00000000", {mem_addr, mem_wdata, hit_cnt, miss_cnt}); else pass_cnt++;
        total_cnt++; if (n_mem_req + n_ack !== 0) $display("FAIL reset_req_ignored: got %0d expected 0", n_mem_req + n_ack); else pass_cnt++;
        rst = 1'b0; cpu_req = 1'b0;
        tick();
        tick();
        total_cnt++; if ({cpu_ack, mem_req, cache_we} !== 3'b0) $display("FAIL reset_release_idle: got %b expected 000", {cpu_ack, mem_req, cache_we}); else pass_cnt++;
    endtask

    task automatic test_read_hit();
        cv[8'h12] = 1'b1; cd[8'h12] = 8'hA5;
        run_txn(1'b0, 8'h12, 8'h00, -1, 8'h00);
        total_cnt++; if (n_ack !== 1) $display("FAIL hit_ack_count: got %0d expected 1", n_ack); else pass_cnt++;
        total_cnt++; if (ack_at !== 3) $display("FAIL hit_latency: got %0d expected 3", ack_at); else pass_cnt++;
        total_cnt++; if (ack_rdata !== 8'hA5 || ack_err !== 1'b0) $display("FAIL hit_data: got %h/%b expected a5/0", ack_rdata, ack_err); else pass_cnt++;
        total_cnt++; if (n_mem_req + n_cache_we !== 0) $display("FAIL hit_no_mem_fill: got %0d expected 0", n_mem_req + n_cache_we); else pass_cnt++;
        total_cnt++; if (hit_cnt !== 8'd1 || miss_cnt !== 8'd0) $display("FAIL hit_counters: got %0d/%0d expected 1/0", hit_cnt, miss_cnt); else pass_cnt++;
    endtask

    task automatic test_read_miss();
        cv[8'h34] = 1'b0;
        run_txn(1'b0, 8'h34, 8'h00, 5, 8'h5C);
        total_cnt++; if (n_mem_req !== 6 || m_we !== 1'b0 || m_addr !== 8'h34) $display("FAIL miss_mem_req: got %0d/%b/%h expected 6/0/34", n_mem_req, m_we, m_addr); else pass_cnt++;
        total_cnt++; if (mem_unstable !== 1'b0) $display("FAIL miss_mem_stable: got %b expected 0", mem_unstable); else pass_cnt++;
        total_cnt++; if (n_cache_we !== 1 || fill_addr !== 8'h34 || fill_data !== 8'h5C) $display("FAIL miss_fill: got %0d/%h/%h expected 1/34/5c", n_cache_we, fill_addr, fill_data); else pass_cnt++;
        total_cnt++; if (ack_at !== 10 || n_ack !== 1) $display("FAIL miss_latency: got %0d/%0d expected 10/1", ack_at, n_ack); else pass_cnt++;
        total_cnt++; if (ack_rdata !== 8'h5C || ack_err !== 1'b0) $display("FAIL miss_data: got %h/%b expected 5c/0", ack_rdata, ack_err); else pass_cnt++;
        total_cnt++; if (hit_cnt !== 8'd1 || miss_cnt !== 8'd1) $display("FAIL miss_counters: got %0d/%0d expected 1/1", hit_cnt, miss_cnt); else pass_cnt++;
        run_txn(1'b0, 8'h34, 8'h00, -1, 8'h00);
        total_cnt++; if (ack_at !== 3 || ack_rdata !== 8'h5C || n_mem_req !== 0) $display("FAIL refill_hit: got %0d/%h/%0d expected 3/5c/0", ack_at, ack_rdata, n_mem_req); else pass_cnt++;
        total_cnt++; if (hit_cnt !== 8'd2) $display("FAIL refill_hit_cnt: got %0d expected 2", hit_cnt); else pass_cnt++;
    endtask

    task automatic test_write();
        run_txn(1'b1, 8'h40, 8'h99, 3, 8'h00);
        total_cnt++; if (n_mem_req !== 4 || m_we !== 1'b1 || m_addr !== 8'h40 || m_wdata !== 8'h99) $display("FAIL write_mem: got %0d/%b/%h/%h expected 4/1/40/99", n_mem_req, m_we, m_addr, m_wdata); else pass_cnt++;
        total_cnt++; if (n_cache_we !== 1 || fill_addr !== 8'h40 || fill_data !== 8'h99) $display("FAIL write_fill: got %0d/%h/%h expected 1/40/99", n_cache_we, fill_addr, fill_data); else pass_cnt++;
        total_cnt++; if (ack_at !== 6 || n_ack !== 1 || ack_err !== 1'b0) $display("FAIL write_ack: got %0d/%0d/%b expected 6/1/0", ack_at, n_ack, ack_err); else pass_cnt++;
        total_cnt++; if (hit_cnt !== 8'd2 || miss_cnt !== 8'd1) $display("FAIL write_counters: got %0d/%0d expected 2/1", hit_cnt, miss_cnt); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int waited;
        clear_stats();
        mem_delay = -1;
        cpu_we = 1'b0; cpu_addr = 8'h60; cpu_req = 1'b1;
        waited = 0;
        while (n_mem_req < 3 && waited < 40) begin
            tick(); waited++;
            if (cyc == 1) cpu_req = 1'b0;
        end
        total_cnt++; if (n_mem_req !== 3) $display("FAIL midrst_reach_memrd: got %0d expected 3", n_mem_req); else pass_cnt++;
        rst = 1'b1;
        tick();
        total_cnt++; if (mem_req !== 1'b0 || cpu_ack !== 1'b0) $display("FAIL midrst_drop: got %b/%b expected 0/0", mem_req, cpu_ack); else pass_cnt++;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        total_cnt++; if (n_ack + n_cache_we !== 0 || mem_req !== 1'b0) $display("FAIL midrst_aborted: got %0d/%b expected 0/0", n_ack + n_cache_we, mem_req); else pass_cnt++;
        total_cnt++; if (hit_cnt !== 8'd0 || miss_cnt !== 8'd0) $display("FAIL midrst_counters: got %0d/%0d expected 0/0", hit_cnt, miss_cnt); else pass_cnt++;
    endtask

    task automatic test_saturation();
        cv[8'h12] = 1'b1; cd[8'h12] = 8'hA5;
        for (int i = 0; i < 254; i++) run_txn(1'b0, 8'h12, 8'h00, -1, 8'h00);
        total_cnt++; if (hit_cnt !== 8'hFE) $display("FAIL sat_254: got %h expected fe", hit_cnt); else pass_cnt++;
        run_txn(1'b0, 8'h12, 8'h00, -1, 8'h00);
        total_cnt++; if (hit_cnt !== 8'hFF) $display("FAIL sat_255: got %h expected ff", hit_cnt); else pass_cnt++;
        run_txn(1'b0, 8'h12, 8'h00, -1, 8'h00);
        total_cnt++; if (hit_cnt !== 8'hFF || miss_cnt !== 8'h00) $display("FAIL sat_256: got %h/%h expected ff/00", hit_cnt, miss_cnt); else pass_cnt++;
    endtask

    task automatic test_timeout();
        rst = 1'b1; tick(); tick();
        rst = 1'b0; sel = 1'b1; tick();
        cv[8'h50] = 1'b0; cv[8'h51] = 1'b0;
        run_txn(1'b0, 8'h50, 8'h00, -1, 8'h00);
        total_cnt++; if (n_mem_req !== 5) $display("FAIL tmo_req_cycles: got %0d expected 5", n_mem_req); else pass_cnt++;
        total_cnt++; if (ack_at !== 8 || n_ack !== 1) $display("FAIL tmo_latency: got %0d/%0d expected 8/1", ack_at, n_ack); else pass_cnt++;
        total_cnt++; if (ack_err !== 1'b1 || ack_rdata !== 8'hFF || n_err !== 1) $display("FAIL tmo_error: got %b/%h/%0d expected 1/ff/1", ack_err, ack_rdata, n_err); else pass_cnt++;
        total_cnt++; if (n_cache_we !== 0 || miss_cnt !== 8'd1) $display("FAIL tmo_no_fill: got %0d/%0d expected 0/1", n_cache_we, miss_cnt); else pass_cnt++;
        run_txn(1'b0, 8'h51, 8'h00, 4, 8'h3C);
        total_cnt++; if (ack_at !== 9 || ack_err !== 1'b0 || n_err !== 0) $display("FAIL tmo_edge_ack: got %0d/%b/%0d expected 9/0/0", ack_at, ack_err, n_err); else pass_cnt++;
        total_cnt++; if (ack_rdata !== 8'h3C || n_cache_we !== 1 || fill_data !== 8'h3C) $display("FAIL tmo_edge_data: got %h/%0d/%h expected 3c/1/3c", ack_rdata, n_cache_we, fill_data); else pass_cnt++;
        run_txn(1'b1, 8'h52, 8'h11, -1, 8'h00);
        total_cnt++; if (ack_at !== 6 || ack_err !== 1'b1 || n_cache_we !== 0) $display("FAIL tmo_write: got %0d/%b/%0d expected 6/1/0", ack_at, ack_err, n_cache_we); else pass_cnt++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            cv[i] = 1'b0; cd[i] = 8'h00;
        end
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
        cache_hit = 1'b0; cache_rdata = 8'h00; mem_ack = 1'b0; mem_rdata = 8'h00;
        test_reset();
        test_read_hit();
        test_read_miss();
        test_write();
        test_reset_mid();
        test_saturation();
        test_timeout();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/cache_miss_ctrl.md
Name: cache_miss_ctrl

Overview:
Memory-access controller between the CPU data port and the lookup cache, with backing RAM behind it. CPU reads are looked up in the cache first. A read miss fetches the byte from backing memory and fills the cache. Writes go through to backing memory and update the cache. The block also provides a bounded-latency error path and hit/miss statistics.

Parameters:
ADDR_WIDTH, 8, address width on all ports
DATA_WIDTH, 8, data width on all ports
MEM_TIMEOUT, 64, max cycles waiting for mem_ack before erroring (>=2)
STAT_WIDTH, 8, width of saturating hit/miss counters

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
cpu_req  in  1  request level, sampled only in IDLE
cpu_we  in  1  1=write, 0=read; captured with cpu_req
cpu_addr  in  ADDR_WIDTH  request address; captured with cpu_req
cpu_wdata  in  DATA_WIDTH  write data; captured with cpu_req
cpu_rdata  out  DATA_WIDTH  read result; registered, valid while cpu_ack=1
cpu_ack  out  1  one-cycle completion pulse
cpu_err  out  1  qualifies cpu_ack: backing-memory timeout
cache_addr  out  ADDR_WIDTH  cache lookup/fill address
cache_we  out  1  cache fill strobe, one cycle
cache_wdata  out  DATA_WIDTH  fill data; top level drives cache inout data from this when cache_we=1
cache_rdata  in  DATA_WIDTH  cache read data, registered by cache one edge after cache_addr
cache_hit  in  1  cache hit, registered by cache one edge after cache_addr
mem_req  out  1  backing-memory request, held until mem_ack or timeout
mem_we  out  1  backing write when 1
mem_addr  out  ADDR_WIDTH  backing address
mem_wdata  out  DATA_WIDTH  backing write data
mem_rdata  in  DATA_WIDTH  backing read data, valid with mem_ack
mem_ack  in  1  backing completion, single cycle
hit_cnt  out  STAT_WIDTH  read hits, saturating
miss_cnt  out  STAT_WIDTH  read misses, saturating

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - state=IDLE.
  - cpu_ack, cpu_err, cache_we, mem_req and mem_we are 0.
  - cpu_rdata, cache_addr, cache_wdata, mem_addr, mem_wdata, hit_cnt and miss_cnt are 0.
  - rst mid-transaction aborts it: no ack, no fill, and mem_req drops after that edge.
- States: IDLE, LOOKUP, CHECK, MEM_RD, MEM_WR, FILL, RESP.
- IDLE:
  - If cpu_req=1, capture we/addr/wdata.
  - Read goes to LOOKUP; write goes to MEM_WR.
  - cache_addr is driven from the captured address in every state.
- LOOKUP: one cycle; the cache samples cache_addr. Go to CHECK.
- CHECK:
  - cache_hit=1: cpu_rdata<=cache_rdata, hit_cnt+1, go to RESP.
  - cache_hit=0: miss_cnt+1, go to MEM_RD.
- MEM_RD and MEM_WR:
  - mem_req=1 with a stable address (and data for writes); mem_we=1 in MEM_WR only.
  - The timeout counter is cleared on entry and increments each cycle.
  - mem_ack=1: MEM_RD latches mem_rdata into cpu_rdata and the fill data; MEM_WR uses the captured wdata as fill data. Both go to FILL.
  - Counter reaches MEM_TIMEOUT with mem_ack=0: cpu_err<=1, cpu_rdata<=all ones, go to RESP with no fill.
  - mem_ack in the same cycle the timeout expires: ack wins, no error.
  - mem_ack outside MEM_RD/MEM_WR is ignored.
- FILL: cache_we=1 for exactly one cycle with cache_addr and cache_wdata. Go to RESP.
- RESP: cpu_ack=1 for one cycle, cpu_err as set. Go to IDLE; cpu_err clears with ack.
- Latency, counted from the cycle cpu_req is sampled as cycle 0:
  - read hit: ack in cycle 3;
  - read miss: ack 2 cycles after the mem_ack cycle;
  - write: ack 2 cycles after mem_ack;
  - timeout: ack in cycle MEM_TIMEOUT+2 (write) or MEM_TIMEOUT+4 (read).
- Handshake:
  - cpu_req is ignored outside IDLE.
  - A req still high in the cycle after ack is a new request; the requester must drop req in the ack cycle to avoid back-to-back issue.
- Counters saturate at all ones and never wrap. Writes do not count.

Decomposition:
- Shared include/package holds:
  - state encodings;
  - the timeout-error data constant (all ones);
  - the default widths.
- One sub-module is natural: sat_counter (parameter WIDTH; inputs clk, rst, inc; output count, saturating). It is instantiated twice, for hit_cnt and miss_cnt.
- The FSM and the timeout counter stay in cache_miss_ctrl.

Test Plan:
- Reset with rst=1 for 2 cycles -> all outputs 0, state IDLE; cpu_req=1 while rst=1 produces no mem_req and no ack.
- Read 0x12, cache model returns hit=1, rdata=0xA5 -> cpu_ack in cycle 3 with cpu_rdata=0xA5, cpu_err=0; hit_cnt=1; no mem_req, no cache_we.
- Read 0x34 miss, mem_ack after 5 cycles with 0x5C -> one mem_req burst (mem_we=0, mem_addr=0x34); one-cycle cache_we with addr 0x34 and data 0x5C; ack with cpu_rdata=0x5C; miss_cnt=1.
- Write 0x40<=0x99, mem_ack after 3 cycles -> mem_we=1, mem_wdata=0x99; cache_we with 0x40/0x99; ack, no lookup, counters unchanged.
- Read miss with MEM_TIMEOUT=4 and mem_ack never asserted -> mem_req drops after 4 cycles; ack with cpu_err=1, cpu_rdata=0xFF; no cache_we. Repeat with mem_ack on the expiry cycle -> normal completion, cpu_err=0.
- Reset asserted mid MEM_RD -> mem_req 0 after that edge, no ack. Then 256 read hits with STAT_WIDTH=8 -> hit_cnt holds at 0xFF.
